ifetch_unit: RTL and testbench
==============================

IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 SHALL have parameter XLEN, default 64, meaning width of the program counter and pc_o.
REQ-002 SHALL have parameter RESET_PC, default 0, meaning the byte address fetched first after reset.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, a power of two ≥2, meaning the depth of the instruction buffer.
REQ-004 SHALL have port clk_i  input  1  clock; all logic on the rising edge.
REQ-005 SHALL have port aresetn_i  input  1  reset, synchronous and active-low.
REQ-006 SHALL have port imem_req_o  output  1  read request to the instruction memory this cycle.
REQ-007 SHALL have port imem_addr_o  output  32  word address of the request, equal to fetch PC[33:2].
REQ-008 SHALL have port imem_instr_i  input  32  read data, valid exactly one cycle after a request.
REQ-009 SHALL have port redirect_i  input  1  branch/jump redirect strobe.
REQ-010 SHALL have port redirect_pc_i  input  XLEN  byte target of the redirect.
REQ-011 SHALL have port valid_o  output  1  instr_o/pc_o hold a valid instruction.
REQ-012 SHALL have port ready_i  input  1  the decode stage accepts the instruction.
REQ-013 SHALL have port instr_o  output  32  instruction at the FIFO head.
REQ-014 SHALL have port pc_o  output  XLEN  byte PC of instr_o.
REQ-015 SHALL have port fault_o  output  1  misaligned-redirect fault (see Configuration).

Function
REQ-016 SHALL implement FSM states IDLE, FETCH, FAULT; IDLE→FETCH on the first cycle out of reset; FETCH→FAULT only per REQ-030; FAULT is left only by reset.
REQ-017 SHALL assert imem_req_o in FETCH only when FIFO occupancy + outstanding requests < FIFO_DEPTH, and not in a cycle with redirect_i high.
REQ-018 SHALL advance fetch PC by 4 on each issued request, wrapping modulo 2^XLEN.
REQ-019 SHALL write imem_instr_i and its PC into the FIFO the cycle after an unkilled request.
REQ-020 SHALL transfer an entry only on a cycle with valid_o && ready_i, popping the head.
REQ-021 SHALL keep instr_o and pc_o stable while valid_o && !ready_i.
REQ-022 SHALL, when the FIFO is full, issue no request, and SHALL never drop or overwrite an entry.
REQ-023 SHALL allow a push and a pop in the same cycle, leaving occupancy unchanged.
REQ-024 SHALL, on redirect_i, flush the FIFO, kill any in-flight response, and set fetch PC to redirect_pc_i; the first request to the new PC issues the following cycle.
REQ-025 SHALL gate valid_o low in a cycle with redirect_i high; no transfer occurs in that cycle.
REQ-026 SHALL hold valid_o=0 and imem_req_o=0 in FAULT.
REQ-027 SHALL give a sustained throughput of one instruction per cycle when ready_i is held high, with first valid_o 2 cycles after reset release or redirect.

Reset
REQ-028 SHALL, with aresetn_i low at a rising edge, set fetch PC=RESET_PC, FIFO empty, outstanding=0, kill=0, state=IDLE, valid_o=0, imem_req_o=0, fault_o=0, instr_o=0, pc_o=0.
REQ-029 SHALL give reset priority over redirect_i and all handshakes, discarding any in-flight response.

Configuration
REQ-030 SHALL, when macro IFETCH_MISALIGN_CHECK_EN is defined, enter FAULT and set fault_o=1 (sticky until reset) when redirect_i is high with redirect_pc_i[1:0]≠0.
REQ-031 SHALL, when the macro is undefined, tie fault_o to 0, never enter FAULT, and force redirect_pc_i[1:0] to 0.

Structure
REQ-032 SHALL place the state enum type ifetch_state_t and the localparam INSTR_W=32 in the shared package ifetch_pkg.
REQ-033 SHALL implement the buffer as sub-module ifetch_fifo, holding {pc, instr} entries with full/empty/count outputs.

Verification
REQ-034 SHALL cover: reset release with ready_i=1 and imem loaded 0x00000013 at all words → valid_o at cycle 2, pc_o 0x0,0x4,0x8 on consecutive cycles.
REQ-035 SHALL cover: ready_i=0 for 10 cycles → exactly 4 requests issued, valid_o held with pc_o=0x0; on ready_i=1, pc_o 0x0..0xC streams with no gap.
REQ-036 SHALL cover: redirect_i with redirect_pc_i=0x100 while 2 requests are in flight → no stale entry reaches decode, next pc_o=0x100 at 2 cycles.
REQ-037 SHALL cover: redirect_i high in the same cycle as valid_o && ready_i → valid_o=0 that cycle, no transfer counted.
REQ-038 SHALL cover: with IFETCH_MISALIGN_CHECK_EN, redirect to 0x102 → fault_o=1 next cycle, imem_req_o=0 thereafter; without the macro, the next pc_o is 0x100.
REQ-039 SHALL cover: reset asserted mid-stream with 3 FIFO entries → next cycle valid_o=0 and fetch restarts at RESET_PC.

Source files
------------

// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifetch_pkg;

    localparam int unsigned INSTR_W     = 32;
    localparam int unsigned IMEM_ADDR_W = 32;
    localparam int unsigned PC_STEP     = 4;

    // Fetch control states; FAULT is only reachable with the misalign check built in.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        FAULT = 2'd2
    } ifetch_state_t;

endpackage

// File: rtl/ifetch_fifo.sv
// Instruction buffer: circular FIFO of {pc, instr} entries with synchronous
// flush. Push and pop may happen in the same cycle, including when full.
module ifetch_fifo
    import ifetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PC_W  = 64,
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic               clk_i,
    input  logic               aresetn_i,
    input  logic               flush_i,
    input  logic               push_i,
    input  logic [PC_W-1:0]    push_pc_i,
    input  logic [INSTR_W-1:0] push_instr_i,
    input  logic               pop_i,
    output logic [PC_W-1:0]    head_pc_o,
    output logic [INSTR_W-1:0] head_instr_o,
    output logic               full_o,
    output logic               empty_o,
    output logic [CNT_W-1:0]   count_o
);

    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned ENTRY_W = PC_W + INSTR_W;

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic               do_push;
    logic               do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

    // A full FIFO only accepts a push when the head leaves in the same cycle.
    assign do_push = push_i && (!full_o || pop_i);
    assign do_pop  = pop_i && !empty_o;

    assign {head_pc_o, head_instr_o} = mem_q[rd_ptr_q];

    // Entry storage; cleared on reset so the head reads zero.
    always_ff @(posedge clk_i) begin
        if (!aresetn_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (do_push && !flush_i) begin
            mem_q[wr_ptr_q] <= {push_pc_i, push_instr_i};
        end
    end

    // Pointers and occupancy; flush empties the buffer without touching storage.
    always_ff @(posedge clk_i) begin
        if (!aresetn_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch unit: issues sequential word reads to a one-cycle-latency
// instruction memory, buffers responses and hands them to decode with a
// valid/ready handshake. Redirects flush the buffer and restart fetch.
// Optional build macro IFETCH_MISALIGN_CHECK_EN: a redirect to a non-word
// aligned target raises a sticky fault and stops fetch. Without it the
// target's low two bits are ignored.
module ifetch_unit
    import ifetch_pkg::*;
#(
    parameter int unsigned    XLEN       = 64,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter int unsigned    FIFO_DEPTH = 4
) (
    input  logic                   clk_i,
    input  logic                   aresetn_i,
    output logic                   imem_req_o,
    output logic [IMEM_ADDR_W-1:0] imem_addr_o,
    input  logic [INSTR_W-1:0]     imem_instr_i,
    input  logic                   redirect_i,
    input  logic [XLEN-1:0]        redirect_pc_i,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic [INSTR_W-1:0]     instr_o,
    output logic [XLEN-1:0]        pc_o,
    output logic                   fault_o
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned OCC_W = CNT_W + 1;

    ifetch_state_t state_q;
    ifetch_state_t state_d;

    logic [XLEN-1:0]  fetch_pc_q;
    logic [XLEN-1:0]  fetch_pc_d;
    logic [XLEN-1:0]  req_pc_q;
    logic             resp_pend_q;
    logic [XLEN-1:0]  redirect_tgt;
    logic             misalign;
    logic             take_redirect;
    logic             has_room;
    logic [OCC_W-1:0] occupancy;

    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_flush;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;

`ifdef IFETCH_MISALIGN_CHECK_EN
    logic fault_q;

    assign misalign     = (redirect_pc_i[1:0] != 2'b00);
    assign redirect_tgt = redirect_pc_i;

    // Sticky fault flag, raised together with the move into FAULT.
    always_ff @(posedge clk_i) begin
        if (!aresetn_i) begin
            fault_q <= 1'b0;
        end else if (state_d == FAULT) begin
            fault_q <= 1'b1;
        end
    end

    assign fault_o = fault_q;
`else
    assign misalign     = 1'b0;
    assign redirect_tgt = redirect_pc_i & ~XLEN'(3);
    assign fault_o      = 1'b0;
`endif

    // Entries plus the response still on its way must fit in the buffer.
    assign occupancy     = OCC_W'(fifo_count) + OCC_W'(resp_pend_q);
    assign has_room      = (occupancy < OCC_W'(FIFO_DEPTH));
    assign take_redirect = redirect_i && (state_q != FAULT);

    assign imem_addr_o = IMEM_ADDR_W'(fetch_pc_q >> 2);

    // State register.
    always_ff @(posedge clk_i) begin
        if (!aresetn_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus request, handshake and buffer control.
    always_comb begin
        state_d    = state_q;
        imem_req_o = 1'b0;
        valid_o    = 1'b0;
        fifo_push  = 1'b0;
        fifo_pop   = 1'b0;
        fifo_flush = 1'b0;
        case (state_q)
            IDLE: begin
                state_d    = FETCH;
                fifo_flush = redirect_i;
            end
            FETCH: begin
                imem_req_o = !redirect_i && has_room;
                valid_o    = !redirect_i && !fifo_empty;
                fifo_pop   = valid_o && ready_i;
                // A redirect kills the response arriving this cycle.
                fifo_push  = resp_pend_q && !redirect_i;
                fifo_flush = redirect_i;
                if (redirect_i && misalign) begin
                    state_d = FAULT;
                end
            end
            FAULT: begin
                state_d = FAULT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Fetch PC: redirect target wins, otherwise step past each issued request.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (take_redirect) begin
            fetch_pc_d = redirect_tgt;
        end else if (imem_req_o) begin
            fetch_pc_d = fetch_pc_q + XLEN'(PC_STEP);
        end
    end

    // Fetch PC and the PC/pending flag of the request awaiting its response.
    always_ff @(posedge clk_i) begin
        if (!aresetn_i) begin
            fetch_pc_q  <= RESET_PC;
            req_pc_q    <= '0;
            resp_pend_q <= 1'b0;
        end else begin
            fetch_pc_q  <= fetch_pc_d;
            resp_pend_q <= imem_req_o;
            if (imem_req_o) begin
                req_pc_q <= fetch_pc_q;
            end
        end
    end

    ifetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .PC_W  (XLEN)
    ) u_fifo (
        .clk_i        (clk_i),
        .aresetn_i    (aresetn_i),
        .flush_i      (fifo_flush),
        .push_i       (fifo_push),
        .push_pc_i    (req_pc_q),
        .push_instr_i (imem_instr_i),
        .pop_i        (fifo_pop),
        .head_pc_o    (pc_o),
        .head_instr_o (instr_o),
        .full_o       (fifo_full),
        .empty_o      (fifo_empty),
        .count_o      (fifo_count)
    );

    // Request gating keeps pushes within capacity; a push into a full,
    // non-draining buffer would lose an instruction.
    always_ff @(posedge clk_i) begin
        if (aresetn_i) begin
            assert (!(fifo_push && fifo_full && !fifo_pop))
                else $error("ifetch_fifo overflow");
        end
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: directed latency/backpressure/redirect/reset cases
// followed by randomized ready/redirect traffic checked through a scoreboard.
module tb_ifetch_unit;

    localparam logic [63:0] RESET_PC = 64'h0;

    logic        clk;
    logic        aresetn_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_instr_i;
    logic        redirect_i;
    logic [63:0] redirect_pc_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] instr_o;
    logic [63:0] pc_o;
    logic        fault_o;

    ifetch_unit #(
        .XLEN       (64),
        .RESET_PC   (RESET_PC),
        .FIFO_DEPTH (4)
    ) dut (
        .clk_i         (clk),
        .aresetn_i     (aresetn_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_instr_i  (imem_instr_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .valid_o       (valid_o),
        .ready_i       (ready_i),
        .instr_o       (instr_o),
        .pc_o          (pc_o),
        .fault_o       (fault_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t        sb_q[$];
    logic [63:0] model_pc;
    bit          model_fault;
    bit          mem_const;
    int          n_cmp;
    int          n_bad;
    int          n_xfer;

    function automatic logic [31:0] mem_word(input logic [31:0] waddr);
        if (mem_const) return 32'h0000_0013;
        return (waddr * 32'h9E37_79B1) ^ 32'h5A5A_0013;
    endfunction

    // Instruction memory: data appears one cycle after the request.
    always @(posedge clk) begin
        imem_instr_i <= imem_req_o ? mem_word(imem_addr_o) : 32'hDEAD_BEEF;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Keep the in-order expected stream topped up from the model PC.
    task automatic refill();
        while (!model_fault && sb_q.size() < 8) begin
            sb_q.push_back('{pc: model_pc, instr: mem_word(model_pc[33:2])});
            model_pc = model_pc + 64'd4;
        end
    endtask

    task automatic apply_redirect(input logic [63:0] tgt);
        redirect_i    = 1'b1;
        redirect_pc_i = tgt;
        sb_q.delete();
`ifdef IFETCH_MISALIGN_CHECK_EN
        if (tgt[1:0] != 2'b00) model_fault = 1'b1;
        else model_pc = tgt;
`else
        model_pc = {tgt[63:2], 2'b00};
`endif
        refill();
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_cyc(input string name, input logic v, input logic [63:0] pc);
        @(negedge clk);
        chk({name, ".valid"}, valid_o, v);
        if (v) chk({name, ".pc"}, pc_o, pc);
        nxt();
    endtask

    // Hold reset two edges, check the reset state, release; returns in cycle 0.
    task automatic do_reset(input bit cnst, input logic rdy);
        aresetn_i     = 1'b0;
        ready_i       = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = '0;
        sb_q.delete();
        model_pc      = RESET_PC;
        model_fault   = 1'b0;
        mem_const     = cnst;
        nxt();
        @(negedge clk);
        chk("rst.valid", valid_o, 0);
        chk("rst.req", imem_req_o, 0);
        chk("rst.fault", fault_o, 0);
        chk("rst.pc", pc_o, 0);
        chk("rst.instr", instr_o, 0);
        nxt();
        aresetn_i = 1'b1;
        ready_i   = rdy;
        refill();
        nxt();
    endtask

    task automatic redirect_check(input string name, input logic [63:0] tgt, input logic [63:0] exp_pc);
        apply_redirect(tgt);
        @(negedge clk);
        chk({name, ".gate_valid"}, valid_o, 0);
        chk({name, ".gate_req"}, imem_req_o, 0);
        nxt();
        redirect_i = 1'b0;
        expect_cyc({name, ".c1"}, 1'b0, '0);
        expect_cyc({name, ".c2"}, 1'b0, '0);
        expect_cyc({name, ".first"}, 1'b1, exp_pc);
    endtask

    // Monitor: scoreboard pops on every transfer; held entries must stay put.
    logic        hold_v;
    logic [63:0] hold_pc;
    logic [31:0] hold_instr;
    always @(negedge clk) begin
        if (!aresetn_i) begin
            hold_v <= 1'b0;
        end else begin
            if (hold_v && !redirect_i) begin
                chk("mon.hold_valid", valid_o, 1);
                chk("mon.hold_pc", pc_o, hold_pc);
                chk("mon.hold_instr", instr_o, hold_instr);
            end
            if (redirect_i) begin
                chk("mon.redir_valid", valid_o, 0);
                chk("mon.redir_req", imem_req_o, 0);
            end
            if (valid_o && ready_i) begin
                n_xfer++;
                if (sb_q.size() == 0) begin
                    chk("mon.sb_underflow", pc_o, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk("mon.pc", pc_o, e.pc);
                    chk("mon.instr", instr_o, 64'(e.instr));
                end
            end
            hold_v     <= valid_o && !ready_i && !redirect_i;
            hold_pc    <= pc_o;
            hold_instr <= instr_o;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        int          nreq;
        int          xfer_start;
        logic [63:0] tgt;
        n_cmp = 0;
        n_bad = 0;
        n_xfer = 0;
        aresetn_i = 1'b0;
        ready_i = 1'b0;
        redirect_i = 1'b0;
        redirect_pc_i = '0;
        mem_const = 1'b1;
        model_fault = 1'b0;
        model_pc = RESET_PC;

        // Latency out of reset and full-rate streaming.
        do_reset(1'b1, 1'b1);
        @(negedge clk);
        chk("boot.c0.req", imem_req_o, 1);
        chk("boot.c0.valid", valid_o, 0);
        nxt();
        expect_cyc("boot.c1", 1'b0, '0);
        expect_cyc("boot.c2", 1'b1, 64'h0);
        expect_cyc("boot.c3", 1'b1, 64'h4);
        expect_cyc("boot.c4", 1'b1, 64'h8);

        // Backpressure: requests stop at buffer capacity, head held.
        do_reset(1'b0, 1'b0);
        nreq = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (imem_req_o) nreq++;
            nxt();
        end
        chk("bp.req_count", 64'(nreq), 64'd4);
        @(negedge clk);
        chk("bp.held_valid", valid_o, 1);
        chk("bp.held_pc", pc_o, 64'h0);
        nxt();
        ready_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            expect_cyc("bp.drain", 1'b1, 64'(4 * i));
        end

        // Redirect in the middle of a full-rate stream.
        redirect_check("redir100", 64'h100, 64'h100);
        expect_cyc("redir100.next", 1'b1, 64'h104);

        // Misaligned redirect target.
`ifdef IFETCH_MISALIGN_CHECK_EN
        apply_redirect(64'h102);
        @(negedge clk);
        chk("mis.gate_valid", valid_o, 0);
        nxt();
        redirect_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("mis.fault", fault_o, 1);
            chk("mis.req", imem_req_o, 0);
            chk("mis.valid", valid_o, 0);
            nxt();
        end
        do_reset(1'b0, 1'b1);
        repeat (4) nxt();
`else
        redirect_check("mis", 64'h102, 64'h100);
        @(negedge clk);
        chk("mis.fault", fault_o, 0);
        nxt();
`endif

        // PC wraps past the top of the address space.
        redirect_check("wrap", 64'hFFFF_FFFF_FFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFF8);
        expect_cyc("wrap.n1", 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
        expect_cyc("wrap.n2", 1'b1, 64'h0);
        expect_cyc("wrap.n3", 1'b1, 64'h4);

        // Reset while three entries are buffered.
        do_reset(1'b0, 1'b0);
        repeat (4) nxt();
        @(negedge clk);
        chk("midrst.pre_valid", valid_o, 1);
        chk("midrst.pre_count", 64'(sb_q.size()), 64'd8);
        #1;
        do_reset(1'b0, 1'b1);
        @(negedge clk);
        chk("midrst.c0.req", imem_req_o, 1);
        chk("midrst.c0.addr", 64'(imem_addr_o), 64'(RESET_PC[33:2]));
        nxt();
        expect_cyc("midrst.c1", 1'b0, '0);
        expect_cyc("midrst.c2", 1'b1, RESET_PC);

        // Randomized ready and redirect traffic.
        do_reset(1'b0, 1'b1);
        xfer_start = n_xfer;
        for (int i = 0; i < 3000; i++) begin
            ready_i = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) begin
                tgt = {$urandom, $urandom};
                if ($urandom_range(0, 3) == 0) tgt[63:8] = '1;
`ifdef IFETCH_MISALIGN_CHECK_EN
                tgt[1:0] = 2'b00;
`endif
                apply_redirect(tgt);
            end else begin
                redirect_i    = 1'b0;
                redirect_pc_i = {$urandom, $urandom};
                refill();
            end
            nxt();
        end
        redirect_i = 1'b0;
        ready_i    = 1'b1;
        repeat (10) begin
            refill();
            nxt();
        end
        chk("rand.progress", 64'(n_xfer - xfer_start >= 500), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
